// File: rtl/stop_watch_counter.sv
// Purpose : stopwatch time base; prescales clk to 1/100 s ticks and counts mm:ss.cc.
// Latency : one clk from cnt_ctrl to every output (all outputs registered); first tick on the TICK_DIV-th enabled edge.
// Backpressure: none; cnt_ctrl is a level command sampled every edge, outputs are always valid.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   cnt_ctrl[1:0]     ENABLE runs, DISABLE pauses, RESET (and 2'b11) clears
//   o_csec/o_sec/o_min  binary time 0..99 / 0..59 / 0..59
//   o_running         registered (cnt_ctrl == ENABLE)
//   o_wrap            one-cycle pulse when 59:59.99 rolls over to 00:00.00
//   SW_LAP_EN (macro) adds i_lap, o_lap_csec, o_lap_sec, o_lap_min, o_lap_valid
module stop_watch_counter #(
  parameter int         TICK_DIV = 500000,
  parameter logic [1:0] ENABLE   = 2'b00,
  parameter logic [1:0] DISABLE  = 2'b01,
  parameter logic [1:0] RESET    = 2'b10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] cnt_ctrl,
`ifdef SW_LAP_EN
  input  logic       i_lap,
  output logic [6:0] o_lap_csec,
  output logic [5:0] o_lap_sec,
  output logic [5:0] o_lap_min,
  output logic       o_lap_valid,
`endif
  output logic [6:0] o_csec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic       o_running,
  output logic       o_wrap
);

  localparam int            PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    csec_q, csec_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic          running_q;
  logic          wrap_q, wrap_d;

  logic run;
  logic clr;
  logic tick;

  assign run  = (cnt_ctrl == ENABLE);
  // 2'b11 is not a legal command; treat it as a clear so the counter never sits in an undefined mode
  assign clr  = (cnt_ctrl == RESET) || (cnt_ctrl == 2'b11);
  // Tick is qualified by run: leaving ENABLE in the terminal cycle leaves the prescaler parked at LAST
  assign tick = run && (presc_q == LAST);

  always_comb begin
    presc_d = presc_q;
    csec_d  = csec_q;
    sec_d   = sec_q;
    min_d   = min_q;
    wrap_d  = 1'b0;
    if (clr) begin
      presc_d = '0;
      csec_d  = '0;
      sec_d   = '0;
      min_d   = '0;
    end else if (tick) begin
      presc_d = '0;
      if (csec_q == 7'd99) begin
        csec_d = '0;
        if (sec_q == 6'd59) begin
          sec_d = '0;
          if (min_q == 6'd59) begin
            min_d  = '0;
            wrap_d = 1'b1;
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        csec_d = csec_q + 7'd1;
      end
    end else if (run) begin
      presc_d = presc_q + PW'(1);
    end else if (cnt_ctrl == DISABLE) begin
      // pause: prescaler phase and time hold, wrap drops to 0
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      csec_q    <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      csec_q    <= csec_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      running_q <= run;
      wrap_q    <= wrap_d;
    end
  end

`ifdef SW_LAP_EN
  // Lap captures the pre-edge time; a clear wins over a simultaneous lap request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_lap_csec  <= '0;
      o_lap_sec   <= '0;
      o_lap_min   <= '0;
      o_lap_valid <= 1'b0;
    end else if (clr) begin
      o_lap_csec  <= '0;
      o_lap_sec   <= '0;
      o_lap_min   <= '0;
      o_lap_valid <= 1'b0;
    end else if (i_lap) begin
      o_lap_csec  <= csec_q;
      o_lap_sec   <= sec_q;
      o_lap_min   <= min_q;
      o_lap_valid <= 1'b1;
    end
  end
`endif

  assign o_csec    = csec_q;
  assign o_sec     = sec_q;
  assign o_min     = min_q;
  assign o_running = running_q;
  assign o_wrap    = wrap_q;

endmodule

// File: tb/tb_stop_watch_counter.sv
// Purpose : directed self-checking bench for stop_watch_counter with TICK_DIV=4.
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a; stimulus drives cnt_ctrl levels directly.
module tb_stop_watch_counter;

  localparam logic [1:0] EN  = 2'b00;
  localparam logic [1:0] DIS = 2'b01;
  localparam logic [1:0] CLR = 2'b10;

  logic       clk;
  logic       rst;
  logic [1:0] cnt_ctrl;
  logic [6:0] csec;
  logic [5:0] sec;
  logic [5:0] min;
  logic       running;
  logic       wrap;
`ifdef SW_LAP_EN
  logic       lap;
  logic [6:0] lap_csec;
  logic [5:0] lap_sec;
  logic [5:0] lap_min;
  logic       lap_valid;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  stop_watch_counter #(
    .TICK_DIV(4),
    .ENABLE  (2'b00),
    .DISABLE (2'b01),
    .RESET   (2'b10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_ctrl   (cnt_ctrl),
`ifdef SW_LAP_EN
    .i_lap      (lap),
    .o_lap_csec (lap_csec),
    .o_lap_sec  (lap_sec),
    .o_lap_min  (lap_min),
    .o_lap_valid(lap_valid),
`endif
    .o_csec     (csec),
    .o_sec      (sec),
    .o_min      (min),
    .o_running  (running),
    .o_wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply a command for n edges; returns 1 unit after the last edge
  task automatic step(input logic [1:0] c, input int n);
    cnt_ctrl = c;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic preset_max();
    cnt_ctrl = DIS;
    force dut.csec_q = 7'd99;
    force dut.sec_q  = 6'd59;
    force dut.min_q  = 6'd59;
    step(DIS, 1);
    release dut.csec_q;
    release dut.sec_q;
    release dut.min_q;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    cnt_ctrl = CLR;
`ifdef SW_LAP_EN
    lap = 1'b0;
`endif
    #1;
    n_checks++;
    if ({csec, sec, min, running, wrap} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_immediate: got %0d:%0d.%0d run=%b wrap=%b, expected all 0", min, sec, csec, running, wrap);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    step(CLR, 2);
    n_checks++;
    if ({csec, sec, min, running, wrap} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_release: got %0d:%0d.%0d run=%b wrap=%b, expected all 0", min, sec, csec, running, wrap);
    end
  endtask

  task automatic test_latency();
    step(EN, 3);
    n_checks++;
    if (csec !== 7'd0 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_pre: got csec=%0d run=%b, expected csec=0 run=1", csec, running);
    end
    step(EN, 1);
    n_checks++;
    if (csec !== 7'd1) begin
      n_fail++;
      $display("FAIL latency_tick: got csec=%0d, expected 1", csec);
    end
    step(EN, 396);
    n_checks++;
    if (csec !== 7'd0 || sec !== 6'd1 || min !== 6'd0) begin
      n_fail++;
      $display("FAIL sec_carry: got %0d:%0d.%0d, expected 0:1.0", min, sec, csec);
    end
  endtask

  task automatic test_pause();
    step(CLR, 1);
    step(EN, 2);
    step(DIS, 10);
    n_checks++;
    if (running !== 1'b0 || csec !== 7'd0) begin
      n_fail++;
      $display("FAIL pause_hold: got run=%b csec=%0d, expected run=0 csec=0", running, csec);
    end
    step(EN, 1);
    n_checks++;
    if (csec !== 7'd0 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_resume3: got csec=%0d run=%b, expected csec=0 run=1", csec, running);
    end
    step(EN, 1);
    n_checks++;
    if (csec !== 7'd1) begin
      n_fail++;
      $display("FAIL pause_resume4: got csec=%0d, expected 1", csec);
    end
  endtask

  task automatic test_terminal_exit();
    step(CLR, 1);
    step(EN, 3);
    step(DIS, 1);
    n_checks++;
    if (csec !== 7'd0) begin
      n_fail++;
      $display("FAIL terminal_no_tick: got csec=%0d, expected 0", csec);
    end
    // prescaler parked at TICK_DIV-1, so a single enabled edge ticks
    step(EN, 1);
    n_checks++;
    if (csec !== 7'd1) begin
      n_fail++;
      $display("FAIL terminal_hold: got csec=%0d, expected 1", csec);
    end
  endtask

  task automatic test_rollover();
    step(CLR, 1);
    preset_max();
    step(EN, 3);
    n_checks++;
    if (csec !== 7'd99 || sec !== 6'd59 || min !== 6'd59 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL rollover_pre: got %0d:%0d.%0d wrap=%b, expected 59:59.99 wrap=0", min, sec, csec, wrap);
    end
    step(EN, 1);
    n_checks++;
    if (csec !== 7'd0 || sec !== 6'd0 || min !== 6'd0 || wrap !== 1'b1) begin
      n_fail++;
      $display("FAIL rollover: got %0d:%0d.%0d wrap=%b, expected 0:0.0 wrap=1", min, sec, csec, wrap);
    end
    step(EN, 1);
    n_checks++;
    if (wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_pulse_width: got wrap=%b, expected 0", wrap);
    end
    // second rollover followed by a pause: wrap must drop
    step(CLR, 1);
    preset_max();
    step(EN, 4);
    step(DIS, 1);
    n_checks++;
    if (wrap !== 1'b0 || csec !== 7'd0) begin
      n_fail++;
      $display("FAIL wrap_under_disable: got wrap=%b csec=%0d, expected wrap=0 csec=0", wrap, csec);
    end
  endtask

  task automatic test_code11();
    step(CLR, 1);
    step(EN, 4936);
    n_checks++;
    if (csec !== 7'd34 || sec !== 6'd12 || min !== 6'd0) begin
      n_fail++;
      $display("FAIL reach_12_34: got %0d:%0d.%0d, expected 0:12.34", min, sec, csec);
    end
    step(2'b11, 1);
    n_checks++;
    if (csec !== 7'd0 || sec !== 6'd0 || min !== 6'd0 || running !== 1'b0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL code11_clear: got %0d:%0d.%0d run=%b wrap=%b, expected all 0", min, sec, csec, running, wrap);
    end
    step(EN, 4);
    n_checks++;
    if (csec !== 7'd1 || sec !== 6'd0) begin
      n_fail++;
      $display("FAIL resume_after_clear: got %0d.%0d, expected 0.1", sec, csec);
    end
  endtask

  task automatic test_async_reset();
    step(CLR, 1);
    step(EN, 2);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (running !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got run=%b, expected 0", running);
    end
    step(EN, 1);
    rst = 1'b0;
    step(EN, 3);
    n_checks++;
    if (csec !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_discards_phase: got csec=%0d, expected 0", csec);
    end
    step(EN, 1);
    n_checks++;
    if (csec !== 7'd1) begin
      n_fail++;
      $display("FAIL reset_resume: got csec=%0d, expected 1", csec);
    end
  endtask

`ifdef SW_LAP_EN
  task automatic test_lap();
    step(CLR, 1);
    step(EN, 148);
    lap = 1'b1;
    step(EN, 1);
    lap = 1'b0;
    n_checks++;
    if (lap_csec !== 7'd37 || lap_valid !== 1'b1 || csec !== 7'd37) begin
      n_fail++;
      $display("FAIL lap_capture: got lap=%0d valid=%b csec=%0d, expected lap=37 valid=1 csec=37", lap_csec, lap_valid, csec);
    end
    step(EN, 3);
    n_checks++;
    if (csec !== 7'd38 || lap_csec !== 7'd37) begin
      n_fail++;
      $display("FAIL lap_hold: got csec=%0d lap=%0d, expected csec=38 lap=37", csec, lap_csec);
    end
    lap = 1'b1;
    step(CLR, 1);
    lap = 1'b0;
    n_checks++;
    if (lap_valid !== 1'b0 || lap_csec !== 7'd0) begin
      n_fail++;
      $display("FAIL lap_reset_wins: got valid=%b lap=%0d, expected valid=0 lap=0", lap_valid, lap_csec);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_pause();
    test_terminal_exit();
    test_rollover();
    test_code11();
    test_async_reset();
`ifdef SW_LAP_EN
    test_lap();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
